alu_pipe_hs: RTL and testbench
==============================

Name: alu_pipe_hs

Overview:
- Parametrised, registered successor to the 8-bit combinational bitwise AND unit: a W-bit ALU with opcode select, status flags and valid/ready handshakes on input and output.
- One result register between the operand source (switch/UART front end or datapath) and the consumer. A result is produced one cycle after acceptance and is held until the consumer takes it.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- OPW, 6, opcode width (MIPS funct encoding).
- SHW, $clog2(W), number of shift-amount bits taken from B (local).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  unit can accept operands this cycle.
- A  in  W  operand A.
- B  in  W  operand B (shift amount in B[SHW-1:0] for shifts).
- op  in  OPW  operation code.
- out_valid  out  1  Z and flags hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- Z  out  W  registered result.
- zero  out  1  Z == 0.
- carry  out  1  ADD carry-out / SUB borrow; 0 for other ops.
- ovf  out  1  signed overflow for ADD/SUB; 0 for other ops.
- err  out  1  opcode not supported; Z = 0.

Behaviour:
- Reset: reset is asynchronous and active-high. While asserted: out_valid=0, Z=0, zero=0, carry=0, ovf=0, err=0. in_ready=1 once out_valid=0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Accept: in_valid && in_ready at a rising edge. On the same edge, Z and the flags load and out_valid is set to 1. Latency is 1 cycle.
- Release: out_valid && out_ready && !(accept) at an edge sets out_valid to 0. Z and the flags keep their last values; they are don't-care while out_valid=0.
- Simultaneous release and accept: the new result replaces the old one and out_valid stays 1. Full throughput is 1 op/cycle.
- Stall: while out_valid=1 and out_ready=0, Z and all flags are held bit-stable. in_ready=0, and A, B and op are ignored.
- Opcodes (op value = operation):
  - 100000 ADD: Z = (A+B) mod 2^W.
  - 100010 SUB: Z = (A-B) mod 2^W.
  - 100100 AND: Z = A&B.
  - 100101 OR: Z = A|B.
  - 100110 XOR: Z = A^B.
  - 100111 NOR: Z = ~(A|B).
  - 000010 SRL: logical right shift.
  - 000011 SRA: arithmetic right shift.
  - Any other value: Z = 0, err = 1.
- Shifts: the amount is s = B[SHW-1:0].
  - If s >= W (possible when W is not a power of 2): SRL gives Z=0; SRA gives every bit = A[W-1].
- Flags:
  - carry: ADD = bit W of the (W+1)-bit sum. SUB = 1 when A < B unsigned.
  - ovf: ADD = (A[W-1]==B[W-1]) && (Z[W-1]!=A[W-1]). SUB = (A[W-1]!=B[W-1]) && (Z[W-1]!=A[W-1]).
  - zero: computed on the registered Z for every op, including invalid ones (invalid op gives zero=1).
- Reset mid-operation: a pending result is discarded with no output handshake. The first accept after reset is released is a normal transaction.
- No combinational path from A, B or op to any output. The only combinational output path is out_ready -> in_ready.

Test Plan:
- W=8, reset high then low; A=8'hCC, B=8'h3F, op=AND, in_valid for 1 cycle, out_ready=1 -> next edge Z=8'h0C, out_valid=1 for 1 cycle, zero=0, carry=0, ovf=0, err=0.
- ADD 8'h7F+8'h01 -> Z=8'h80, ovf=1, carry=0. ADD 8'hFF+8'h01 -> Z=8'h00, carry=1, zero=1, ovf=0.
- SUB 8'h00-8'h01 -> Z=8'hFF, carry=1, ovf=0. SUB 8'h80-8'h01 -> Z=8'h7F, ovf=1. SRA 8'h90, B=3 -> Z=8'hF2. SRL 8'h90, B=3 -> Z=8'h12.
- Backpressure: out_ready=0, issue OR 8'hF0|8'h0F then present XOR in the next cycle -> Z=8'hFF held, in_ready=0 for 3 cycles, XOR not taken. Raise out_ready -> same-edge release+accept, Z=XOR result, out_valid stays 1.
- Back-to-back stream of 16 random ops with out_ready=1 -> 16 results in order, one per cycle; each result matches a reference model. Repeat with W=12 and SRA/SRL, s=13 -> SRL gives Z=0, SRA gives sign fill.
- Invalid op=6'b111111 -> Z=0, err=1, zero=1. Assert reset while out_valid=1 and out_ready=0 -> out_valid and Z clear immediately without a clock edge, and in_ready=1 after reset is released.

Source files
------------

// File: rtl/alu_pipe_hs.sv
// W-bit ALU with one registered result stage and valid/ready handshakes.
// Opcodes follow MIPS funct encoding; unsupported opcodes give Z=0, err=1.
module alu_pipe_hs #(
    parameter int W   = 8,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [OPW-1:0] op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   Z,
    output logic           zero,
    output logic           carry,
    output logic           ovf,
    output logic           err
);
    localparam int SHW = $clog2(W);

    localparam logic [OPW-1:0] OP_ADD = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SUB = OPW'(6'b100010);
    localparam logic [OPW-1:0] OP_AND = OPW'(6'b100100);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6'b100101);
    localparam logic [OPW-1:0] OP_XOR = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_NOR = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SRL = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_SRA = OPW'(6'b000011);

    logic [W:0]     sum;
    logic [W:0]     dif;
    logic [SHW-1:0] s;
    logic [W-1:0]   n_z;
    logic           n_carry;
    logic           n_ovf;
    logic           n_err;
    logic           accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Shift operators already yield 0 / sign fill when s >= W.
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        dif     = {1'b0, A} - {1'b0, B};
        s       = B[SHW-1:0];
        n_z     = '0;
        n_carry = 1'b0;
        n_ovf   = 1'b0;
        n_err   = 1'b0;
        unique case (op)
            OP_ADD: begin
                n_z     = sum[W-1:0];
                n_carry = sum[W];
                n_ovf   = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                n_z     = dif[W-1:0];
                n_carry = dif[W];
                n_ovf   = (A[W-1] != B[W-1]) && (dif[W-1] != A[W-1]);
            end
            OP_AND:  n_z = A & B;
            OP_OR:   n_z = A | B;
            OP_XOR:  n_z = A ^ B;
            OP_NOR:  n_z = ~(A | B);
            OP_SRL:  n_z = A >> s;
            OP_SRA:  n_z = W'($signed(A) >>> s);
            default: n_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            Z         <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            Z         <= n_z;
            zero      <= (n_z == '0);
            carry     <= n_carry;
            ovf       <= n_ovf;
            err       <= n_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs: directed vectors, handshake corner cases and
// random streams at W=8 and W=12 against an arithmetic reference model.
module tb_alu_pipe_hs;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8;
    logic [7:0] a8, b8, z8;
    logic [5:0] op8;
    logic       zr8, cy8, ovf8, er8;

    logic        iv12, ir12, ov12, or12;
    logic [11:0] a12, b12, z12;
    logic [5:0]  op12;
    logic        zr12, cy12, ovf12, er12;

    alu_pipe_hs #(.W(8), .OPW(6)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
        .Z(z8), .zero(zr8), .carry(cy8), .ovf(ovf8), .err(er8)
    );

    alu_pipe_hs #(.W(12), .OPW(6)) dut12 (
        .clk(clk), .reset(reset), .in_valid(iv12), .in_ready(ir12),
        .A(a12), .B(b12), .op(op12), .out_valid(ov12), .out_ready(or12),
        .Z(z12), .zero(zr12), .carry(cy12), .ovf(ovf12), .err(er12)
    );

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;

    typedef struct {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic [3:0] fl;
    } vec_t;

    typedef struct {
        longint z;
        logic [3:0] fl;
    } res_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fl = {zero, carry, ovf, err}
    function automatic res_t model(input int w, input logic [5:0] o,
                                   input longint a, input longint b);
        res_t r;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint sa = (a >= half) ? a - (longint'(1) << w) : a;
        longint sb = (b >= half) ? b - (longint'(1) << w) : b;
        longint sr;
        int shw = 0;
        longint s;
        logic c = 1'b0, v = 1'b0, e = 1'b0;
        while ((1 << shw) < w) shw++;
        s = b % (longint'(1) << shw);
        r.z = 0;
        case (o)
            ADD: begin
                r.z = (a + b) & mask; c = (a + b) > mask;
                sr = sa + sb; v = (sr < -half) || (sr >= half);
            end
            SUB: begin
                r.z = (a - b) & mask; c = a < b;
                sr = sa - sb; v = (sr < -half) || (sr >= half);
            end
            AND: r.z = a & b;
            OR:  r.z = a | b;
            XOR: r.z = a ^ b;
            NOR: r.z = ~(a | b) & mask;
            SRL: r.z = (s >= w) ? 0 : (a >> s);
            SRA: r.z = (sa >>> s) & mask;
            default: e = 1'b1;
        endcase
        r.fl = {r.z == 0, c, v, e};
        return r;
    endfunction

    task automatic issue8(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b);
        op8 = o; a8 = a; b8 = b; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic issue12(input logic [5:0] o, input logic [11:0] a, input logic [11:0] b);
        op12 = o; a12 = a; b12 = b; iv12 = 1'b1;
        @(posedge clk); #1;
        iv12 = 1'b0;
    endtask

    vec_t vt[9];
    logic [5:0] ops[8] = '{ADD, SUB, AND, OR, XOR, NOR, SRL, SRA};

    initial begin
        res_t m;
        logic [5:0] ro;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
        iv12 = 0; or12 = 1; a12 = 0; b12 = 0; op12 = 0;

        vt[0] = '{AND, 8'hCC, 8'h3F, 8'h0C, 4'b0000};
        vt[1] = '{ADD, 8'h7F, 8'h01, 8'h80, 4'b0010};
        vt[2] = '{ADD, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vt[3] = '{SUB, 8'h00, 8'h01, 8'hFF, 4'b0100};
        vt[4] = '{SUB, 8'h80, 8'h01, 8'h7F, 4'b0010};
        vt[5] = '{SRA, 8'h90, 8'h03, 8'hF2, 4'b0000};
        vt[6] = '{SRL, 8'h90, 8'h03, 8'h12, 4'b0000};
        vt[7] = '{6'b111111, 8'h55, 8'hAA, 8'h00, 4'b1001};
        vt[8] = '{NOR, 8'hF0, 8'h0F, 8'h00, 4'b1000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_z", z8, 0);
        chk("rst_flags", {zr8, cy8, ovf8, er8}, 0);
        chk("rst_in_ready", ir8, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            issue8(vt[i].op, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d_valid", i), ov8, 1);
            chk($sformatf("vec%0d_z", i), z8, vt[i].z);
            chk($sformatf("vec%0d_flags", i), {zr8, cy8, ovf8, er8}, vt[i].fl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_released", i), ov8, 0);
        end

        // Backpressure: OR held, XOR waits, then same-edge release+accept.
        or8 = 1'b0;
        issue8(OR, 8'hF0, 8'h0F);
        op8 = XOR; a8 = 8'hF0; b8 = 8'h3C; iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", ir8, 0);
            chk("bp_z_held", z8, 8'hFF);
            chk("bp_valid", ov8, 1);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        #1;
        chk("bp_in_ready_comb", ir8, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("bp_swap_valid", ov8, 1);
        chk("bp_swap_z", z8, 8'hCC);
        @(posedge clk); #1;
        chk("bp_done", ov8, 0);

        // Random back-to-back streams on both widths.
        iv8 = 1'b1; iv12 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            res_t m12;
            ro = (($urandom % 8) == 0) ? 6'($urandom) : ops[$urandom % 8];
            op8 = ro; a8 = 8'($urandom); b8 = 8'($urandom);
            ro = (($urandom % 8) == 0) ? 6'($urandom) : ops[$urandom % 8];
            op12 = ro; a12 = 12'($urandom); b12 = 12'($urandom);
            m = model(8, op8, longint'(a8), longint'(b8));
            m12 = model(12, op12, longint'(a12), longint'(b12));
            chk("rnd_in_ready", {ir8, ir12}, 2'b11);
            @(posedge clk); #1;
            chk($sformatf("rnd8_%0d_z", i), z8, m.z);
            chk($sformatf("rnd8_%0d_fl", i), {zr8, cy8, ovf8, er8}, m.fl);
            chk($sformatf("rnd12_%0d_z", i), z12, m12.z);
            chk($sformatf("rnd12_%0d_fl", i), {zr12, cy12, ovf12, er12}, m12.fl);
            chk("rnd_valid", {ov8, ov12}, 2'b11);
        end
        iv8 = 1'b0; iv12 = 1'b0;
        @(posedge clk); #1;

        // W=12 shifts with s=13 >= W.
        issue12(SRL, 12'h8A5, 12'd13);
        chk("w12_srl13", z12, 0);
        chk("w12_srl13_zero", zr12, 1);
        issue12(SRA, 12'h8A5, 12'd13);
        chk("w12_sra13_neg", z12, 12'hFFF);
        issue12(SRA, 12'h4A5, 12'd13);
        chk("w12_sra13_pos", z12, 0);
        issue12(SRA, 12'h800, 12'd4);
        chk("w12_sra4", z12, 12'hF80);
        @(posedge clk); #1;

        // Reset while a result is stalled.
        or8 = 1'b0;
        issue8(ADD, 8'h12, 8'h34);
        chk("pre_rst_valid", ov8, 1);
        chk("pre_rst_z", z8, 8'h46);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", ov8, 0);
        chk("async_rst_z", z8, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", ir8, 1);
        or8 = 1'b1;
        @(posedge clk); #1;
        issue8(AND, 8'hCC, 8'h3F);
        chk("post_rst_valid", ov8, 1);
        chk("post_rst_z", z8, 8'h0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
